// File: rtl/upcount_pkg.sv
// Shared definitions for the upcount4bit counter: FSM state encoding and
// the default counter width.
package upcount_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        COUNT = 1'b0,
        HALT  = 1'b1
    } state_t;

endpackage

// File: rtl/upcount4bit.sv
// Loadable up-counter with a programmable terminal value, either wrapping
// or halting at the limit, with terminal-count, done and sticky overflow flags.
module upcount4bit
    import upcount_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter bit ONESHOT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             done_d;
    logic             ovf_d;

    // tc defaults low so it can only ever be a single-cycle pulse.
    always_comb begin
        state_d = state;
        count_d = count;
        tc_d    = 1'b0;
        done_d  = done;
        ovf_d   = ovf;

        if (load) begin
            state_d = COUNT;
            count_d = din;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state)
                COUNT: begin
                    if (en) begin
                        if (count == limit) begin
                            tc_d = 1'b1;
                            if (ONESHOT) begin
                                state_d = HALT;
                                done_d  = 1'b1;
                            end else begin
                                count_d = ZERO;
                                ovf_d   = 1'b1;
                            end
                        end else if (count == ALL_ONES) begin
                            // Loaded above the limit: roll over without a terminal pulse.
                            count_d = ZERO;
                            ovf_d   = 1'b1;
                        end else begin
                            count_d = count + ONE;
                        end
                    end
                end
                HALT: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = COUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= COUNT;
            count <= ZERO;
            tc    <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_d;
            count <= count_d;
            tc    <= tc_d;
            done  <= done_d;
            ovf   <= ovf_d;
        end
    end

endmodule
